// File: rtl/ofs_plat_host_chan_cpl_rd_rsp_assembler.sv
// Read completion assembler: maps host completion beats, tagged by PCIe tag,
// back to AFU read requests and emits per-line responses. Last lines free the tag.
module ofs_plat_host_chan_cpl_rd_rsp_assembler #(
  parameter int PCIE_TAG_WIDTH    = 8,
  parameter int AFU_TAG_WIDTH     = 16,
  parameter int PAYLOAD_LINE_SIZE = 512,
  parameter int MAX_LINES         = 4,
  localparam int CNT_W = $clog2(MAX_LINES + 1),
  localparam int IDX_W = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,

  input  logic                         alloc_valid,
  input  logic [PCIE_TAG_WIDTH-1:0]    alloc_pcie_tag,
  input  logic [AFU_TAG_WIDTH-1:0]     alloc_afu_tag,
  input  logic [CNT_W-1:0]             alloc_line_count,

  input  logic                         cpl_valid,
  output logic                         cpl_ready,
  input  logic [PCIE_TAG_WIDTH-1:0]    cpl_pcie_tag,
  input  logic [PAYLOAD_LINE_SIZE-1:0] cpl_payload,

  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [PAYLOAD_LINE_SIZE-1:0] rsp_payload,
  output logic [AFU_TAG_WIDTH-1:0]     rsp_afu_tag,
  output logic [IDX_W-1:0]             rsp_line_idx,
  output logic                         rsp_last,

  output logic                         free_valid,
  output logic [PCIE_TAG_WIDTH-1:0]    free_pcie_tag,

  output logic                         err_alloc_busy,
  output logic                         err_unexpected
);

  localparam int NUM_TAGS = 2 ** PCIE_TAG_WIDTH;

  logic [NUM_TAGS-1:0]      r_valid;
  logic [AFU_TAG_WIDTH-1:0] r_afu_tag    [NUM_TAGS];
  logic [CNT_W-1:0]         r_line_count [NUM_TAGS];
  logic [IDX_W-1:0]         r_next_idx   [NUM_TAGS];

  logic                         r_rsp_valid;
  logic [PAYLOAD_LINE_SIZE-1:0] r_rsp_payload;
  logic [AFU_TAG_WIDTH-1:0]     r_rsp_afu_tag;
  logic [IDX_W-1:0]             r_rsp_line_idx;
  logic                         r_rsp_last;
  logic                         r_free_valid;
  logic [PCIE_TAG_WIDTH-1:0]    r_free_pcie_tag;
  logic                         r_err_alloc_busy;
  logic                         r_err_unexpected;

  logic             w_cpl_accept;
  logic             w_hit;
  logic [IDX_W-1:0] w_cur_idx;
  logic [CNT_W-1:0] w_cnt_m1;
  logic             w_last;
  logic             w_emit;

  // Single output register: a new beat is taken only when the slot is empty or draining.
  assign cpl_ready    = !r_rsp_valid || rsp_ready;
  assign w_cpl_accept = cpl_valid && cpl_ready;
  assign w_hit        = r_valid[cpl_pcie_tag];
  assign w_cur_idx    = r_next_idx[cpl_pcie_tag];
  assign w_cnt_m1     = r_line_count[cpl_pcie_tag] - CNT_W'(1);
  assign w_last       = (CNT_W'(w_cur_idx) == w_cnt_m1);
  assign w_emit       = w_cpl_accept && w_hit;

  // Valid bits; the alloc write is last so it wins over a same-tag completion clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else begin
      if (w_emit && w_last) r_valid[cpl_pcie_tag] <= 1'b0;
      if (alloc_valid)      r_valid[alloc_pcie_tag] <= 1'b1;
    end
  end

  // NOTE: the payload side of the table has no reset; r_valid alone qualifies it,
  // which keeps the wide arrays as plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (w_emit) r_next_idx[cpl_pcie_tag] <= w_cur_idx + IDX_W'(1);
    if (alloc_valid) begin
      r_afu_tag[alloc_pcie_tag]    <= alloc_afu_tag;
      r_line_count[alloc_pcie_tag] <= alloc_line_count;
      r_next_idx[alloc_pcie_tag]   <= '0;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge table contents regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid      <= 1'b0;
      r_rsp_payload    <= '0;
      r_rsp_afu_tag    <= '0;
      r_rsp_line_idx   <= '0;
      r_rsp_last       <= 1'b0;
      r_free_valid     <= 1'b0;
      r_free_pcie_tag  <= '0;
      r_err_alloc_busy <= 1'b0;
      r_err_unexpected <= 1'b0;
    end else begin
      r_free_valid <= w_emit && w_last;
      if (w_emit) begin
        r_rsp_valid    <= 1'b1;
        r_rsp_payload  <= cpl_payload;
        r_rsp_afu_tag  <= r_afu_tag[cpl_pcie_tag];
        r_rsp_line_idx <= w_cur_idx;
        r_rsp_last     <= w_last;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      if (w_emit && w_last) r_free_pcie_tag <= cpl_pcie_tag;
      if (alloc_valid && r_valid[alloc_pcie_tag]) r_err_alloc_busy <= 1'b1;
      if (w_cpl_accept && !w_hit)                 r_err_unexpected <= 1'b1;
    end
  end

  assign rsp_valid      = r_rsp_valid;
  assign rsp_payload    = r_rsp_payload;
  assign rsp_afu_tag    = r_rsp_afu_tag;
  assign rsp_line_idx   = r_rsp_line_idx;
  assign rsp_last       = r_rsp_last;
  assign free_valid     = r_free_valid;
  assign free_pcie_tag  = r_free_pcie_tag;
  assign err_alloc_busy = r_err_alloc_busy;
  assign err_unexpected = r_err_unexpected;

  a_alloc_line_count : assert property (@(posedge clk) disable iff (!reset_n)
    alloc_valid |-> (alloc_line_count >= CNT_W'(1) && alloc_line_count <= CNT_W'(MAX_LINES)));

endmodule

// File: tb/tb_ofs_plat_host_chan_cpl_rd_rsp_assembler.sv
// Scoreboard bench: directed scenarios plus random interleaved traffic against
// a per-tag request model; a negedge monitor checks every presented response.
module tb_ofs_plat_host_chan_cpl_rd_rsp_assembler;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         alloc_valid;
  logic [7:0]   alloc_pcie_tag;
  logic [15:0]  alloc_afu_tag;
  logic [2:0]   alloc_line_count;
  logic         cpl_valid;
  logic         cpl_ready;
  logic [7:0]   cpl_pcie_tag;
  logic [511:0] cpl_payload;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [511:0] rsp_payload;
  logic [15:0]  rsp_afu_tag;
  logic [1:0]   rsp_line_idx;
  logic         rsp_last;
  logic         free_valid;
  logic [7:0]   free_pcie_tag;
  logic         err_alloc_busy;
  logic         err_unexpected;

  always #5 clk = ~clk;

  ofs_plat_host_chan_cpl_rd_rsp_assembler dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_pcie_tag(alloc_pcie_tag),
    .alloc_afu_tag(alloc_afu_tag), .alloc_line_count(alloc_line_count),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_pcie_tag(cpl_pcie_tag),
    .cpl_payload(cpl_payload),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload(rsp_payload),
    .rsp_afu_tag(rsp_afu_tag), .rsp_line_idx(rsp_line_idx), .rsp_last(rsp_last),
    .free_valid(free_valid), .free_pcie_tag(free_pcie_tag),
    .err_alloc_busy(err_alloc_busy), .err_unexpected(err_unexpected)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one record per outstanding request, indexed by PCIe tag.
  typedef struct {
    logic [511:0] pay;
    logic [15:0]  afu;
    int           idx;
    bit           last;
  } rsp_t;

  rsp_t        exp_rsp[$];
  int          exp_free[$];
  bit          m_valid [256];
  logic [15:0] m_afu   [256];
  int          m_cnt   [256];
  int          m_done  [256];
  bit          exp_busy;
  bit          exp_unexp;
  int          bp_mode;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_done[i]  = 0;
    end
    exp_rsp.delete();
    exp_free.delete();
    exp_busy  = 1'b0;
    exp_unexp = 1'b0;
  endfunction

  // One clock of stimulus; called just after a rising edge.
  task automatic cyc(input bit av, input int at, input logic [15:0] aa, input int ac,
                     input bit cv, input int ct, output bit acc);
    logic [511:0] pay;
    bit           old_alloc_valid;
    rsp_t         r;
    for (int k = 0; k < 16; k++) pay[k*32 +: 32] = $urandom;
    alloc_valid      = av;
    alloc_pcie_tag   = 8'(at);
    alloc_afu_tag    = aa;
    alloc_line_count = 3'(ac);
    cpl_valid        = cv;
    cpl_pcie_tag     = 8'(ct);
    cpl_payload      = pay;
    @(negedge clk);
    acc = cv && cpl_ready;
    @(posedge clk);
    old_alloc_valid = m_valid[at];
    if (acc) begin
      if (m_valid[ct]) begin
        r.pay  = pay;
        r.afu  = m_afu[ct];
        r.idx  = m_done[ct];
        r.last = (m_done[ct] + 1 == m_cnt[ct]);
        exp_rsp.push_back(r);
        m_done[ct]++;
        if (r.last) begin
          m_valid[ct] = 1'b0;
          exp_free.push_back(ct);
        end
      end else begin
        exp_unexp = 1'b1;
      end
    end
    if (av) begin
      if (old_alloc_valid) exp_busy = 1'b1;
      m_valid[at] = 1'b1;
      m_afu[at]   = aa;
      m_cnt[at]   = ac;
      m_done[at]  = 0;
    end
    #1;
    alloc_valid = 1'b0;
    cpl_valid   = 1'b0;
  endtask

  task automatic alloc(input int tag, input logic [15:0] afu, input int cnt);
    bit acc;
    cyc(1'b1, tag, afu, cnt, 1'b0, 0, acc);
  endtask

  task automatic beat(input int tag);
    bit acc;
    int tries = 0;
    do begin
      cyc(1'b0, 0, 16'h0, 0, 1'b1, tag, acc);
      tries++;
    end while (!acc && tries < 100);
    check("beat_accepted", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 16'h0, 0, 1'b0, 0, acc);
  endtask

  task automatic drain();
    int i = 0;
    while ((exp_rsp.size() != 0 || exp_free.size() != 0) && i < 300) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("drain_rsp_queue", exp_rsp.size(), 0);
    check("drain_free_queue", exp_free.size(), 0);
  endtask

  // Backpressure: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 3) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares presented responses and pulses against the model queues.
  initial begin
    bit           held = 1'b0;
    logic [511:0] h_pay;
    logic [15:0]  h_afu;
    logic [1:0]   h_idx;
    logic         h_last;
    rsp_t         e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held = 1'b0;
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_free_valid", free_valid, 1'b0);
        check("reset_err_busy", err_alloc_busy, 1'b0);
        check("reset_err_unexp", err_unexpected, 1'b0);
        check("reset_rsp_data", {rsp_payload, rsp_afu_tag, rsp_line_idx, rsp_last}, 0);
      end else begin
        check("cpl_ready_rule", cpl_ready, !rsp_valid || rsp_ready);
        check("err_alloc_busy", err_alloc_busy, exp_busy);
        check("err_unexpected", err_unexpected, exp_unexp);
        if (held) begin
          check("hold_valid", rsp_valid, 1'b1);
          check("hold_fields", {rsp_payload, rsp_afu_tag, rsp_line_idx, rsp_last},
                {h_pay, h_afu, h_idx, h_last});
        end
        if (free_valid) begin
          if (exp_free.size() == 0) check("free_unexpected", free_valid, 1'b0);
          else check("free_tag", free_pcie_tag, exp_free.pop_front());
          check("free_with_last", rsp_valid && rsp_last && !held, 1'b1);
        end
        if (rsp_valid && rsp_ready) begin
          held = 1'b0;
          if (exp_rsp.size() == 0) begin
            check("rsp_unexpected_valid", rsp_valid, 1'b0);
          end else begin
            e = exp_rsp.pop_front();
            check("rsp_payload", rsp_payload, e.pay);
            check("rsp_afu_tag", rsp_afu_tag, e.afu);
            check("rsp_line_idx", rsp_line_idx, e.idx);
            check("rsp_last", rsp_last, e.last);
          end
        end else if (rsp_valid) begin
          held   = 1'b1;
          h_pay  = rsp_payload;
          h_afu  = rsp_afu_tag;
          h_idx  = rsp_line_idx;
          h_last = rsp_last;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    bit acc;
    int active[$];
    int t;
    int c;
    reset_n = 1'b0;
    bp_mode = 0;
    alloc_valid = 1'b0; alloc_pcie_tag = '0; alloc_afu_tag = '0; alloc_line_count = '0;
    cpl_valid = 1'b0; cpl_pcie_tag = '0; cpl_payload = '0;
    model_reset();
    #23 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("cpl_ready_after_reset", cpl_ready, 1'b1);

    // Single-line request.
    alloc(5, 16'h1234, 1);
    beat(5);
    idle(2);

    // Four-line request.
    alloc(3, 16'hBEEF, 4);
    for (int i = 0; i < 4; i++) beat(3);
    idle(2);

    // Interleaved tags.
    alloc(1, 16'h0101, 2);
    alloc(2, 16'h0202, 2);
    beat(1); beat(2); beat(1); beat(2);
    idle(2);

    // Backpressure hold with a pending response.
    alloc(11, 16'h0B0B, 2);
    bp_mode = 2;
    idle(2);
    beat(11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_cpl_ready_low", cpl_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    cyc(1'b0, 0, 16'h0, 0, 1'b1, 11, acc);
    check("bp_no_accept", acc, 1'b0);
    bp_mode = 0;
    beat(11);
    idle(3);

    // Completion for an idle tag, then normal traffic still works.
    beat(7);
    alloc(3, 16'h3333, 1);
    beat(3);
    idle(2);

    // Double alloc without completion.
    alloc(9, 16'h0909, 2);
    alloc(9, 16'h9999, 1);
    idle(1);
    check("double_alloc_busy", err_alloc_busy, 1'b1);

    // Same-cycle alloc and completion to one tag: completion sees the old entry.
    alloc(12, 16'hAAAA, 2);
    beat(12);
    idle(1);
    cyc(1'b1, 12, 16'hBBBB, 1, 1'b1, 12, acc);
    check("same_tag_accept", acc, 1'b1);
    beat(12);
    idle(2);

    // Random interleaved traffic with random backpressure.
    bp_mode = 1;
    for (int n = 0; n < 800; n++) begin
      bit av;
      bit cv;
      active.delete();
      for (int i = 16; i < 48; i++) if (m_valid[i]) active.push_back(i);
      t  = 16 + $urandom_range(0, 31);
      av = ($urandom_range(0, 2) == 0) && !m_valid[t];
      cv = ($urandom_range(0, 1) == 1) && (active.size() != 0);
      c  = cv ? active[$urandom_range(0, active.size() - 1)] : 0;
      if (!cv && $urandom_range(0, 15) == 0) begin
        cv = 1'b1;
        c  = 48 + $urandom_range(0, 7);
      end
      cyc(av, t, 16'($urandom), $urandom_range(1, 4), cv, c, acc);
    end
    bp_mode = 0;
    for (int i = 16; i < 48; i++) begin
      int guard = 0;
      while (m_valid[i] && guard < 8) begin
        beat(i);
        guard++;
      end
    end
    drain();

    // Reset mid-request: outputs clear and the table returns to idle.
    alloc(10, 16'h1010, 3);
    beat(10);
    #2 reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_cpl_ready", cpl_ready, 1'b1);
    beat(10);
    idle(2);
    check("post_reset_no_rsp", rsp_valid, 1'b0);
    check("post_reset_unexp", err_unexpected, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
